intersection_scheduler: RTL and testbench

Round-robin phase scheduler for a four-approach intersection. Car sensors from approaches 0..3 request green; the block grants one approach at a time and sequences GREEN -> YELLOW -> all-RED clearance with programmable timing. Fairness comes from latched pending requests and a rotating priority pointer. Light encoding: RED=0, YELLOW=1, GREEN=2.

---
 rtl/intersection_scheduler_if.sv | 32 +++
 rtl/intersection_scheduler.sv | 142 ++++++++++++++
 tb/tb_intersection_scheduler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/intersection_scheduler_if.sv
// Purpose : Bundle of the intersection scheduler's sensor input and light /
//           status outputs.
// Signals : car_req[3:0] - level car sensor per approach (bit i = approach i)
//           lights[7:0]  - 2-bit light code per approach (RED=0, YELLOW=1, GREEN=2)
//           gnt[1:0]     - currently / most recently granted approach
//           phase[1:0]   - 0=IDLE, 1=GREEN, 2=YELLOW, 3=ALLRED
//           busy         - phase != IDLE
// Modports: master drives the sensors (environment side); slave is the
//           scheduler itself.
interface intersection_scheduler_if;
  logic [3:0] car_req;
  logic [7:0] lights;
  logic [1:0] gnt;
  logic [1:0] phase;
  logic       busy;

  modport master (
    output car_req,
    input  lights,
    input  gnt,
    input  phase,
    input  busy
  );

  modport slave (
    input  car_req,
    output lights,
    output gnt,
    output phase,
    output busy
  );
endinterface

// File: rtl/intersection_scheduler.sv
// Purpose : Round-robin green-phase scheduler for a four-approach
//           intersection. One approach is granted at a time and sequenced
//           GREEN -> YELLOW -> all-RED clearance. Requests are latched as
//           pending so short sensor pulses are not lost, and the scan for
//           the next winner starts just after the last granted approach.
// Ports   : clk   - rising-edge clock
//           clear - asynchronous active-high reset
//           bus   - intersection_scheduler_if.slave (car_req in; lights,
//                   gnt, phase, busy out)
// All outputs are decoded from registered state only.
module intersection_scheduler #(
  parameter int T_MIN_GREEN = 4,
  parameter int T_MAX_GREEN = 8,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 2,
  parameter int TW          = 8
) (
  input logic                      clk,
  input logic                      clear,
  intersection_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_ALLRED = 2'd3
  } phase_t;

  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [TW-1:0] MIN_G     = TW'(T_MIN_GREEN);
  localparam logic [TW-1:0] MAX_G     = TW'(T_MAX_GREEN);
  localparam logic [TW-1:0] YEL_T     = TW'(T_YELLOW);
  localparam logic [TW-1:0] RED_T     = TW'(T_ALLRED);

  phase_t        phase_q;
  logic [1:0]    gnt_q;
  logic [3:0]    pending_q;
  logic [TW-1:0] timer_q;

  logic [3:0] req_all;
  logic [3:0] gnt_onehot;
  logic [3:0] pend_set;
  logic [3:0] pend_d;
  logic [3:0] win_onehot;
  logic [1:0] winner;
  logic       any_req;
  logic       other;

  assign req_all    = pending_q | bus.car_req;
  assign any_req    = |req_all;
  assign gnt_onehot = 4'b0001 << gnt_q;
  assign other      = |(req_all & ~gnt_onehot);
  // The granted approach does not re-latch while it is actually green.
  assign pend_set   = bus.car_req & ~((phase_q == PH_GREEN) ? gnt_onehot : 4'b0000);
  assign pend_d     = pending_q | pend_set;
  assign win_onehot = 4'b0001 << winner;

  // Rotating scan gnt+1, gnt+2, gnt+3, gnt; first requester wins.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    winner = gnt_q;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = gnt_q + 2'(k);
      if (!found && req_all[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      phase_q   <= PH_IDLE;
      gnt_q     <= 2'd3;
      pending_q <= 4'b0000;
      timer_q   <= '0;
    end else begin
      pending_q <= pend_d;
      case (phase_q)
        PH_IDLE: begin
          if (any_req) begin
            phase_q   <= PH_GREEN;
            gnt_q     <= winner;
            timer_q   <= TIMER_ONE;
            // Entering green clears the winner's pending bit; clear beats set.
            pending_q <= pend_d & ~win_onehot;
          end
        end
        PH_GREEN: begin
          // MAX_G >= MIN_G, so the pre-emption case is inside the min-green guard.
          if (timer_q >= MIN_G &&
              (!bus.car_req[gnt_q] || (other && timer_q == MAX_G))) begin
            phase_q <= PH_YELLOW;
            timer_q <= TIMER_ONE;
          end else if (timer_q != MAX_G) begin
            timer_q <= timer_q + TIMER_ONE;
          end
        end
        PH_YELLOW: begin
          if (timer_q == YEL_T) begin
            phase_q <= PH_ALLRED;
            timer_q <= TIMER_ONE;
          end else begin
            timer_q <= timer_q + TIMER_ONE;
          end
        end
        default: begin  // PH_ALLRED
          if (timer_q == RED_T) begin
            if (any_req) begin
              phase_q   <= PH_GREEN;
              gnt_q     <= winner;
              timer_q   <= TIMER_ONE;
              pending_q <= pend_d & ~win_onehot;
            end else begin
              phase_q <= PH_IDLE;
              timer_q <= '0;
            end
          end else begin
            timer_q <= timer_q + TIMER_ONE;
          end
        end
      endcase
    end
  end

  // Light decode: only the granted approach is ever non-RED.
  logic [1:0] gnt_code;
  assign gnt_code = (phase_q == PH_GREEN)  ? 2'd2 :
                    (phase_q == PH_YELLOW) ? 2'd1 : 2'd0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_light
    assign bus.lights[2*gi +: 2] = (gnt_q == 2'(gi)) ? gnt_code : 2'd0;
  end

  assign bus.gnt   = gnt_q;
  assign bus.phase = phase_q;
  assign bus.busy  = (phase_q != PH_IDLE);

endmodule

// File: tb/tb_intersection_scheduler.sv
// Self-checking bench for intersection_scheduler. Each stimulus step pushes
// the expected post-edge outputs into a scoreboard queue; after the edge the
// entry is popped and compared against the DUT.
module tb_intersection_scheduler;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  intersection_scheduler_if bus ();

  intersection_scheduler dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    logic [7:0] lights;
    logic [1:0] phase;
    logic [1:0] gnt;
  } exp_t;

  exp_t sb_q[$];
  int   err_cnt = 0;
  int   chk_cnt = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive req for n edges; each edge's expected outputs go through the scoreboard.
  task automatic seg(input string tag, input logic [3:0] req, input logic [7:0] l,
                     input logic [1:0] ph, input logic [1:0] g, input int n);
    exp_t e;
    exp_t o;
    for (int i = 0; i < n; i++) begin
      bus.car_req = req;
      e.tag = tag; e.lights = l; e.phase = ph; e.gnt = g;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      o = sb_q.pop_front();
      check_eq({o.tag, "_lights"}, bus.lights, o.lights);
      check_eq({o.tag, "_phase"}, {6'd0, bus.phase}, {6'd0, o.phase});
      check_eq({o.tag, "_gnt"}, {6'd0, bus.gnt}, {6'd0, o.gnt});
      check_eq({o.tag, "_busy"}, {7'd0, bus.busy}, {7'd0, (o.phase != 2'd0)});
      $display("t=%0t %s req=%b lights=%02h phase=%0d gnt=%0d", $time, o.tag, req,
               bus.lights, bus.phase, bus.gnt);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_lights"}, bus.lights, 8'h00);
    check_eq({tag, "_phase"}, {6'd0, bus.phase}, 8'd0);
    check_eq({tag, "_gnt"}, {6'd0, bus.gnt}, 8'd3);
    check_eq({tag, "_busy"}, {7'd0, bus.busy}, 8'd0);
    $display("t=%0t %s lights=%02h phase=%0d gnt=%0d busy=%0d", $time, tag,
             bus.lights, bus.phase, bus.gnt, bus.busy);
  endtask

  initial begin
    logic [7:0] gcode;
    logic [7:0] ycode;
    clear       = 1'b1;
    bus.car_req = 4'b0000;
    #3;
    check_reset_state("reset");
    repeat (2) @(posedge clk);
    #1 clear = 1'b0;

    // 1: short request on approach 0
    seg("t1_green", 4'b0001, 8'h02, 2'd1, 2'd0, 6);
    seg("t1_yel",   4'b0000, 8'h01, 2'd2, 2'd0, 3);
    seg("t1_ar",    4'b0000, 8'h00, 2'd3, 2'd0, 2);
    seg("t1_idle",  4'b0000, 8'h00, 2'd0, 2'd0, 2);

    // 2: lone held request keeps green indefinitely
    seg("t2_green", 4'b0100, 8'h20, 2'd1, 2'd2, 30);
    seg("t2_yel",   4'b0000, 8'h10, 2'd2, 2'd2, 3);
    seg("t2_ar",    4'b0000, 8'h00, 2'd3, 2'd2, 2);
    seg("t2_idle",  4'b0000, 8'h00, 2'd0, 2'd2, 1);

    // 3: held approach 0 pre-empted at max green by a pulse on approach 2
    seg("t3_green0", 4'b0001, 8'h02, 2'd1, 2'd0, 2);
    seg("t3_green0", 4'b0101, 8'h02, 2'd1, 2'd0, 1);
    seg("t3_green0", 4'b0001, 8'h02, 2'd1, 2'd0, 5);
    seg("t3_yel0",   4'b0001, 8'h01, 2'd2, 2'd0, 3);
    seg("t3_ar0",    4'b0001, 8'h00, 2'd3, 2'd0, 2);
    seg("t3_green2", 4'b0000, 8'h20, 2'd1, 2'd2, 4);
    seg("t3_yel2",   4'b0000, 8'h10, 2'd2, 2'd2, 3);
    seg("t3_ar2",    4'b0000, 8'h00, 2'd3, 2'd2, 2);
    seg("t3_regrant0", 4'b0000, 8'h02, 2'd1, 2'd0, 4);
    seg("t3_yel0b",  4'b0000, 8'h01, 2'd2, 2'd0, 3);
    seg("t3_ar0b",   4'b0000, 8'h00, 2'd3, 2'd0, 2);
    seg("t3_idle",   4'b0000, 8'h00, 2'd0, 2'd0, 1);

    // 4: all four approaches requesting from a fresh reset
    #2 clear = 1'b1;
    #1 clear = 1'b0;
    for (int a = 0; a < 4; a++) begin
      gcode = 8'h02 << (2 * a);
      ycode = 8'h01 << (2 * a);
      seg("t4_green", 4'b1111, gcode, 2'd1, 2'(a), 8);
      seg("t4_yel",   4'b1111, ycode, 2'd2, 2'(a), 3);
      seg("t4_ar",    4'b1111, 8'h00, 2'd3, 2'(a), 2);
    end
    seg("t4_green0", 4'b1111, 8'h02, 2'd1, 2'd0, 8);
    seg("t4_yel0",   4'b0000, 8'h01, 2'd2, 2'd0, 1);

    // 6: clear mid-yellow forces all red before the next edge
    #1 clear = 1'b1;
    #1;
    check_reset_state("t6_clear");
    #1 clear = 1'b0;

    // 6/5: restart grants approach 1; a one-cycle pulse on 3 is latched
    seg("t5_green1", 4'b0010, 8'h08, 2'd1, 2'd1, 1);
    seg("t5_green1", 4'b1010, 8'h08, 2'd1, 2'd1, 1);
    seg("t5_green1", 4'b0010, 8'h08, 2'd1, 2'd1, 2);
    seg("t5_yel1",   4'b0000, 8'h04, 2'd2, 2'd1, 3);
    seg("t5_ar1",    4'b0000, 8'h00, 2'd3, 2'd1, 2);
    seg("t5_green3", 4'b0000, 8'h80, 2'd1, 2'd3, 4);
    seg("t5_yel3",   4'b0000, 8'h40, 2'd2, 2'd3, 3);
    seg("t5_ar3",    4'b0000, 8'h00, 2'd3, 2'd3, 2);
    seg("t5_idle",   4'b0000, 8'h00, 2'd0, 2'd3, 1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
